// File: rtl/angle_ramp_if.sv
// Bus between the switch/command front end and the angle ramp unit.
// The load path has no ready: load_valid is a single-cycle strobe that is
// accepted in every cycle it is high (the unit can always take a new target),
// and load_ch/load_angle are qualified by load_valid in that same cycle.
interface angle_ramp_if #(
  parameter int NUM_CH  = 4,
  parameter int ANGLE_W = 8
);
  localparam int LCH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                      en;
  logic [2*NUM_CH-1:0]       sw;
  logic                      load_valid;
  logic [LCH_W-1:0]          load_ch;
  logic [ANGLE_W-1:0]        load_angle;
  logic [NUM_CH*ANGLE_W-1:0] angle;
  logic [NUM_CH-1:0]         moving;
  logic [NUM_CH-1:0]         at_target;

  modport master (
    output en, sw, load_valid, load_ch, load_angle,
    input  angle, moving, at_target
  );

  modport slave (
    input  en, sw, load_valid, load_ch, load_angle,
    output angle, moving, at_target
  );
endinterface

// File: rtl/angle_ramp_unit.sv
// Multi-channel rate-limited servo angle generator. Each channel holds a
// target (from switch edges or direct loads) and its angle slews toward it
// by at most STEP per prescaled tick, never overshooting.
module angle_ramp_unit #(
  parameter int NUM_CH    = 4,
  parameter int ANGLE_W   = 8,
  parameter int ANGLE_MAX = 180,
  parameter int STEP      = 1,
  parameter int TICK_DIV  = 50000
) (
  input logic         clk,
  input logic         rst,
  angle_ramp_if.slave bus
);
  localparam int PS_W = $clog2(TICK_DIV);

  localparam logic [PS_W-1:0]    PS_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [PS_W-1:0]    PS_ONE  = PS_W'(1);
  localparam logic [ANGLE_W:0]   MAX_X   = (ANGLE_W + 1)'(ANGLE_MAX);
  localparam logic [ANGLE_W:0]   STEP_X  = (ANGLE_W + 1)'(STEP);
  localparam logic [ANGLE_W-1:0] MAX_A   = ANGLE_W'(ANGLE_MAX);

  logic [PS_W-1:0]     prescaler;
  logic                tick;
  logic [2*NUM_CH-1:0] sw_prev;
  logic [ANGLE_W-1:0]  angle_q    [NUM_CH];
  logic [ANGLE_W-1:0]  target     [NUM_CH];
  logic [ANGLE_W-1:0]  target_nxt [NUM_CH];
  logic [ANGLE_W-1:0]  angle_nxt  [NUM_CH];
  logic [ANGLE_W:0]    diff_s     [NUM_CH];
  logic [ANGLE_W:0]    mag        [NUM_CH];
  logic [ANGLE_W:0]    stp        [NUM_CH];
  logic [ANGLE_W:0]    new_x      [NUM_CH];
  logic [NUM_CH-1:0]   moving_v;

  assign tick = bus.en && (prescaler == PS_LAST);

  // Next target: switch edge decode first, then a load on the same channel overrides it.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      target_nxt[i] = target[i];
      if (bus.sw[2*i +: 2] != sw_prev[2*i +: 2]) begin
        if (bus.sw[2*i +: 2] == 2'b00) begin
          target_nxt[i] = '0;
        end else if (bus.sw[2*i +: 2] == 2'b11) begin
          target_nxt[i] = MAX_A;
        end
      end
      if (bus.load_valid && (int'(bus.load_ch) < NUM_CH) && (int'(bus.load_ch) == i)) begin
        target_nxt[i] = ({1'b0, bus.load_angle} > MAX_X) ? MAX_A : bus.load_angle;
      end
    end
  end

  // Next angle: on tick step toward the currently registered target by min(STEP, |diff|).
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      // Extended difference: the top bit is the sign, i.e. the slew direction.
      diff_s[i]    = {1'b0, target[i]} - {1'b0, angle_q[i]};
      mag[i]       = diff_s[i][ANGLE_W] ? (~diff_s[i] + 1'b1) : diff_s[i];
      stp[i]       = (mag[i] < STEP_X) ? mag[i] : STEP_X;
      new_x[i]     = diff_s[i][ANGLE_W] ? ({1'b0, angle_q[i]} - stp[i])
                                        : ({1'b0, angle_q[i]} + stp[i]);
      angle_nxt[i] = angle_q[i];
      if (tick) begin
        // Saturating guard so a step can never wrap the angle.
        angle_nxt[i] = (new_x[i] > MAX_X) ? MAX_A : new_x[i][ANGLE_W-1:0];
      end
    end
  end

  // State registers: prescaler, switch history, per-channel target and angle.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      sw_prev   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        angle_q[i] <= '0;
        target[i]  <= '0;
      end
    end else begin
      sw_prev <= bus.sw;
      if (bus.en) begin
        prescaler <= tick ? '0 : prescaler + PS_ONE;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        angle_q[i] <= angle_nxt[i];
        target[i]  <= target_nxt[i];
      end
    end
  end

  // Outputs come straight from registered angle/target.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign bus.angle[g*ANGLE_W +: ANGLE_W] = angle_q[g];
    assign moving_v[g] = (angle_q[g] != target[g]);
  end

  assign bus.moving    = moving_v;
  assign bus.at_target = ~moving_v;
endmodule

// File: tb/tb_angle_ramp_unit.sv
// Directed bench for angle_ramp_unit with NUM_CH=4, ANGLE_MAX=180, STEP=3, TICK_DIV=4.
module tb_angle_ramp_unit;
  localparam int NUM_CH    = 4;
  localparam int ANGLE_W   = 8;
  localparam int ANGLE_MAX = 180;
  localparam int STEP      = 3;
  localparam int TICK_DIV  = 4;

  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  // Observations collected by watch().
  int   w_chg, w_bad_step, w_bad_gap, w_max;
  bit   w_to;

  angle_ramp_if #(.NUM_CH(NUM_CH), .ANGLE_W(ANGLE_W)) bus ();

  angle_ramp_unit #(
    .NUM_CH(NUM_CH), .ANGLE_W(ANGLE_W), .ANGLE_MAX(ANGLE_MAX),
    .STEP(STEP), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Clock and global time limit.
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [ANGLE_W-1:0] ang(input int ch);
    return bus.angle[ch*ANGLE_W +: ANGLE_W];
  endfunction

  task automatic set_sw(input int ch, input logic [1:0] code);
    bus.sw[2*ch +: 2] = code;
  endtask

  task automatic load(input int ch, input int a);
    bus.load_valid = 1'b1;
    bus.load_ch    = 2'(ch);
    bus.load_angle = 8'(a);
    @(negedge clk);
    bus.load_valid = 1'b0;
  endtask

  // Follows one channel until it reaches tgt (or budget cycles pass), recording
  // step sizes against min(STEP,|tgt-angle|), tick spacing and peak value.
  task automatic watch(input int ch, input int tgt, input int budget);
    int prev, cur, last, cyc, d, st, want;
    w_chg = 0; w_bad_step = 0; w_bad_gap = 0;
    prev  = int'(ang(ch));
    w_max = prev;
    last  = -1;
    cyc   = 0;
    while (prev != tgt && cyc < budget) begin
      @(negedge clk);
      cyc++;
      cur = int'(ang(ch));
      if (cur > w_max) w_max = cur;
      if (cur != prev) begin
        d    = (tgt > prev) ? tgt - prev : prev - tgt;
        st   = (d < STEP) ? d : STEP;
        want = (tgt > prev) ? prev + st : prev - st;
        if (cur != want) w_bad_step++;
        if (last >= 0 && (cyc - last) != TICK_DIV) w_bad_gap++;
        last = cyc;
        w_chg++;
        prev = cur;
      end
    end
    w_to = (prev != tgt);
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    bus.en = 1'b1;
    bus.sw = '0;
    bus.load_valid = 1'b0;
    bus.load_ch = '0;
    bus.load_angle = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.angle !== '0) begin tests_failed++; $display("FAIL reset_angle: got %h want 0", bus.angle); end
    tests_run++;
    if (bus.moving !== 4'h0) begin tests_failed++; $display("FAIL reset_moving: got %h want 0", bus.moving); end
    tests_run++;
    if (bus.at_target !== 4'hF) begin tests_failed++; $display("FAIL reset_at_target: got %h want f", bus.at_target); end
    rst = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.angle !== '0 || bus.at_target !== 4'hF) bad++;
    end
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL idle_100: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_switch_ramp();
    set_sw(0, 2'b11);
    @(negedge clk);
    tests_run++;
    if (bus.moving[0] !== 1'b1) begin tests_failed++; $display("FAIL sw_moving: got %b want 1", bus.moving[0]); end
    watch(0, 180, 300);
    tests_run++;
    if (w_to) begin tests_failed++; $display("FAIL sw_ramp_timeout: got angle %0d want 180", ang(0)); end
    tests_run++;
    if (w_chg != 60) begin tests_failed++; $display("FAIL sw_ramp_ticks: got %0d want 60", w_chg); end
    tests_run++;
    if (w_bad_step != 0 || w_bad_gap != 0) begin
      tests_failed++; $display("FAIL sw_ramp_shape: got %0d bad steps %0d bad gaps want 0 0", w_bad_step, w_bad_gap);
    end
    tests_run++;
    if (bus.at_target !== 4'hF) begin tests_failed++; $display("FAIL sw_settled: got %h want f", bus.at_target); end
    set_sw(0, 2'b01);
    repeat (20) @(negedge clk);
    tests_run++;
    if (ang(0) !== 8'd180 || bus.moving[0] !== 1'b0) begin
      tests_failed++; $display("FAIL sw_01_hold: got %0d moving %b want 180 moving 0", ang(0), bus.moving[0]);
    end
  endtask

  task automatic test_ramp_down();
    set_sw(0, 2'b00);
    watch(0, 0, 300);
    tests_run++;
    if (w_to || w_chg != 60 || w_bad_step != 0 || w_bad_gap != 0 || w_max != 180) begin
      tests_failed++;
      $display("FAIL ramp_down: got angle %0d ticks %0d bad %0d/%0d want 0 60 0/0", ang(0), w_chg, w_bad_step, w_bad_gap);
    end
  endtask

  task automatic test_load();
    load(1, 10);
    tests_run++;
    if (bus.moving[1] !== 1'b1) begin tests_failed++; $display("FAIL load_moving: got %b want 1", bus.moving[1]); end
    watch(1, 10, 100);
    tests_run++;
    if (w_to || w_chg != 4 || w_bad_step != 0 || w_max != 10) begin
      tests_failed++; $display("FAIL load_10: got angle %0d ticks %0d bad %0d max %0d want 10 4 0 10", ang(1), w_chg, w_bad_step, w_max);
    end
    repeat (20) @(negedge clk);
    tests_run++;
    if (ang(1) !== 8'd10 || bus.at_target[1] !== 1'b1) begin
      tests_failed++; $display("FAIL load_10_hold: got %0d want 10", ang(1));
    end
    load(2, 250);
    watch(2, 180, 300);
    repeat (20) @(negedge clk);
    if (int'(ang(2)) > w_max) w_max = int'(ang(2));
    tests_run++;
    if (w_to || w_max != 180 || ang(2) !== 8'd180 || w_chg != 60 || w_bad_step != 0) begin
      tests_failed++; $display("FAIL load_clamp: got angle %0d max %0d ticks %0d want 180 180 60", ang(2), w_max, w_chg);
    end
  endtask

  task automatic test_same_cycle();
    set_sw(0, 2'b11);
    set_sw(3, 2'b11);
    load(3, 90);
    watch(0, 180, 300);
    tests_run++;
    if (w_to || w_chg != 60) begin tests_failed++; $display("FAIL same_cyc_ch0: got angle %0d ticks %0d want 180 60", ang(0), w_chg); end
    tests_run++;
    if (ang(3) !== 8'd90) begin tests_failed++; $display("FAIL same_cyc_ch3: got %0d want 90", ang(3)); end
    tests_run++;
    if (bus.at_target !== 4'hF) begin tests_failed++; $display("FAIL same_cyc_settled: got %h want f", bus.at_target); end
  endtask

  task automatic test_enable();
    int chg;
    set_sw(0, 2'b00);
    watch(0, 0, 300);
    set_sw(0, 2'b11);
    watch(0, 60, 300);
    tests_run++;
    if (w_to) begin tests_failed++; $display("FAIL en_reach_60: got %0d want 60", ang(0)); end
    @(negedge clk);
    bus.en = 1'b0;
    chg = 0;
    repeat (50) begin
      @(negedge clk);
      if (ang(0) !== 8'd60) chg++;
    end
    tests_run++;
    if (chg != 0) begin tests_failed++; $display("FAIL en_hold: got %0d cycles off 60 want 0", chg); end
    bus.en = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (ang(0) !== 8'd60) begin tests_failed++; $display("FAIL en_resume_early: got %0d want 60", ang(0)); end
    @(negedge clk);
    tests_run++;
    if (ang(0) !== 8'd63) begin tests_failed++; $display("FAIL en_resume_step: got %0d want 63", ang(0)); end
  endtask

  task automatic test_reset_mid();
    watch(0, 90, 300);
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.angle !== '0 || bus.moving !== 4'h0 || bus.at_target !== 4'hF) begin
      tests_failed++; $display("FAIL mid_reset: got angle %h moving %h at %h want 0 0 f", bus.angle, bus.moving, bus.at_target);
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.moving[0] !== 1'b1) begin tests_failed++; $display("FAIL post_reset_event: got %b want 1", bus.moving[0]); end
    repeat (2) @(negedge clk);
    tests_run++;
    if (ang(0) !== 8'd0) begin tests_failed++; $display("FAIL post_reset_wait: got %0d want 0", ang(0)); end
    @(negedge clk);
    tests_run++;
    if (ang(0) !== 8'd3) begin tests_failed++; $display("FAIL post_reset_first: got %0d want 3", ang(0)); end
    watch(0, 180, 300);
    tests_run++;
    if (w_to || w_bad_step != 0 || w_bad_gap != 0) begin
      tests_failed++; $display("FAIL post_reset_ramp: got angle %0d bad %0d/%0d want 180 0/0", ang(0), w_bad_step, w_bad_gap);
    end
  endtask

  initial begin
    test_reset();
    test_switch_ramp();
    test_ramp_down();
    test_load();
    test_same_cycle();
    test_enable();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
